// File: rtl/structural_level_gates.sv
// structural_level_gates
//
// Two-input gate bank built from gate-cell instances, with every result
// registered. Computes AND, OR, NOT(a), XOR, XNOR and NAND of a and b.
// The outputs show the inputs sampled at the previous rising edge.
//
// Build option:
//   STRUCT_NAND_ONLY_EN  when defined, every function is built only from
//                        2-input NAND cells. Otherwise each function uses its
//                        own dedicated primitive cell. Port behaviour is the
//                        same in both builds.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset; clears every output flop
//   a, b     in   operands
//   and_g    out  registered a & b
//   or_g     out  registered a | b
//   not_a_g  out  registered ~a
//   xor_g    out  registered a ^ b
//   xnor_g   out  registered ~(a ^ b)
//   nand_g   out  registered ~(a & b)
//   valid    out  high once the outputs hold results from sampled inputs
module structural_level_gates (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic and_g,
  output logic or_g,
  output logic not_a_g,
  output logic xor_g,
  output logic xnor_g,
  output logic nand_g,
  output logic valid
);

  // Combinational result nets
  wire and_n;
  wire or_n;
  wire not_a_n;
  wire xor_n;
  wire xnor_n;
  wire nand_n;

`ifdef STRUCT_NAND_ONLY_EN
  // Each function has its own private NAND cells so the per-function cell
  // count stays fixed: NOT 1, AND 2, OR 3, XOR 4, XNOR 5, NAND 1.

  // NOT a
  nand u_not_0 (not_a_n, a, a);

  // AND: invert the NAND
  wire and_t0;
  nand u_and_0 (and_t0, a, b);
  nand u_and_1 (and_n, and_t0, and_t0);

  // OR: De Morgan, NAND of the inverted operands
  wire or_na;
  wire or_nb;
  nand u_or_0 (or_na, a, a);
  nand u_or_1 (or_nb, b, b);
  nand u_or_2 (or_n, or_na, or_nb);

  // XOR: classic four-NAND form
  wire xor_t0;
  wire xor_t1;
  wire xor_t2;
  nand u_xor_0 (xor_t0, a, b);
  nand u_xor_1 (xor_t1, a, xor_t0);
  nand u_xor_2 (xor_t2, b, xor_t0);
  nand u_xor_3 (xor_n, xor_t1, xor_t2);

  // XNOR: four-NAND XOR followed by a NAND inverter
  wire xnor_t0;
  wire xnor_t1;
  wire xnor_t2;
  wire xnor_x;
  nand u_xnor_0 (xnor_t0, a, b);
  nand u_xnor_1 (xnor_t1, a, xnor_t0);
  nand u_xnor_2 (xnor_t2, b, xnor_t0);
  nand u_xnor_3 (xnor_x, xnor_t1, xnor_t2);
  nand u_xnor_4 (xnor_n, xnor_x, xnor_x);

  // NAND
  nand u_nand_0 (nand_n, a, b);
`else
  and  u_and  (and_n, a, b);
  or   u_or   (or_n, a, b);
  not  u_not  (not_a_n, a);
  xor  u_xor  (xor_n, a, b);
  xnor u_xnor (xnor_n, a, b);
  nand u_nand (nand_n, a, b);
`endif

  // Output stage: reset forces every flop to 0, even where the gate value
  // for the current inputs would be 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      and_g   <= 1'b0;
      or_g    <= 1'b0;
      not_a_g <= 1'b0;
      xor_g   <= 1'b0;
      xnor_g  <= 1'b0;
      nand_g  <= 1'b0;
      valid   <= 1'b0;
    end else begin
      and_g   <= and_n;
      or_g    <= or_n;
      not_a_g <= not_a_n;
      xor_g   <= xor_n;
      xnor_g  <= xnor_n;
      nand_g  <= nand_n;
      valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_structural_level_gates.sv
module tb_structural_level_gates;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic and_g;
  logic or_g;
  logic not_a_g;
  logic xor_g;
  logic xnor_g;
  logic nand_g;
  logic valid;

  int checks = 0;
  int errors = 0;

  structural_level_gates dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .and_g   (and_g),
    .or_g    (or_g),
    .not_a_g (not_a_g),
    .xor_g   (xor_g),
    .xnor_g  (xnor_g),
    .nand_g  (nand_g),
    .valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word: {valid, and, or, not_a, xor, xnor, nand}
  typedef struct {
    logic       a;
    logic       b;
    logic [6:0] exp;
  } vec_t;

  function automatic logic [6:0] outs();
    return {valid, and_g, or_g, not_a_g, xor_g, xnor_g, nand_g};
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (valid,and,or,not_a,xor,xnor,nand)",
               name, got, exp);
    end
    // Invariants, whenever valid is high
    if (valid === 1'b1) begin
      checks++;
      if ((xnor_g !== ~xor_g) || (nand_g !== ~and_g) || (or_g !== (and_g | xor_g))) begin
        errors++;
        $display("FAIL %s invariants: got %b", name, got);
      end
    end
  endtask

  // Drive inputs away from the active edge, then sample 1ns after it.
  task automatic step(input logic r, input logic ia, input logic ib);
    @(negedge clk);
    rst = r;
    a   = ia;
    b   = ib;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{a: 1'b0, b: 1'b1, exp: 7'b1011101};
    vecs[1] = '{a: 1'b1, b: 1'b0, exp: 7'b1010101};
    vecs[2] = '{a: 1'b1, b: 1'b1, exp: 7'b1110010};
    vecs[3] = '{a: 1'b0, b: 1'b0, exp: 7'b1001011};
    vecs[4] = '{a: 1'b1, b: 1'b1, exp: 7'b1110010};
    vecs[5] = '{a: 1'b0, b: 1'b1, exp: 7'b1011101};
    vecs[6] = '{a: 1'b0, b: 1'b0, exp: 7'b1001011};
    vecs[7] = '{a: 1'b1, b: 1'b0, exp: 7'b1010101};

    rst = 1'b1;
    a   = 1'b1;
    b   = 1'b1;

    // Reset held for two edges with a=b=1
    step(1'b1, 1'b1, 1'b1);
    check("reset_edge1", 7'b0000000);
    step(1'b1, 1'b1, 1'b1);
    check("reset_edge2", 7'b0000000);

    // First non-reset edge loads results and raises valid
    step(1'b0, 1'b0, 1'b0);
    check("release_00", 7'b1001011);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Inputs wiggle between edges; outputs must hold until the edge and then
    // reflect only the value present at the edge. Last sampled: a=1,b=0.
    @(negedge clk);
    a = 1'b1; b = 1'b1;
    #1 check("hold_mid_11", 7'b1010101);
    a = 1'b0; b = 1'b0;
    #1 check("hold_mid_00", 7'b1010101);
    a = 1'b1; b = 1'b1;
    @(posedge clk);
    #1 check("toggle_sample_11", 7'b1110010);
    @(negedge clk);
    a = 1'b0; b = 1'b0;
    #1 a = 1'b1;
    #1 b = 1'b1;
    #1 a = 1'b0;
    #1 check("hold_mid_b", 7'b1110010);
    @(posedge clk);
    #1 check("toggle_sample_01", 7'b1011101);

    // One-edge reset mid-stream, inputs discarded
    step(1'b1, 1'b1, 1'b1);
    check("midreset", 7'b0000000);
    step(1'b0, 1'b1, 1'b1);
    check("after_midreset_11", 7'b1110010);
    step(1'b0, 1'b1, 1'b0);
    check("after_midreset_10", 7'b1010101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
